// File: rtl/uart_param.sv
// uart_param: parameterised 8N1-style UART with independent TX/RX tick phases and sticky RX error flags.
// Define UART_RX_FIFO_EN to buffer received bytes in a FIFO_DEPTH FIFO; otherwise a single holding register.
module uart_param #(
    parameter int DIV_W      = 16,
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [3:0]       length,
    input  logic             parity_en,
    input  logic             parity_type,
    input  logic             stop2,
    input  logic             tx_valid,
    input  logic [7:0]       tx_data,
    output logic             tx_ready,
    output logic             tx,
    input  logic             rx,
    output logic             rx_valid,
    output logic [7:0]       rx_data,
    input  logic             rx_ready,
    output logic             rx_parity_err,
    output logic             rx_frame_err,
    output logic             rx_overrun
);
    localparam int            OW       = $clog2(OVS);
    localparam logic [OW-1:0] OVS_LAST = OW'(OVS - 1);
    localparam logic [OW-1:0] OVS_MID  = OW'(OVS / 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} state_t;

    // out-of-range lengths behave as 8 data bits
    logic [2:0] len_m1;
    logic [7:0] len_mask;
    assign len_m1   = (length >= 4'd5 && length <= 4'd8) ? 3'(length - 4'd1) : 3'd7;
    assign len_mask = 8'hFF >> (3'd7 - len_m1);

    state_t           tx_st_q, tx_st_d;
    logic [DIV_W-1:0] tx_div_q, tx_div_d;
    logic [OW-1:0]    tx_ovs_q, tx_ovs_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_sh_q, tx_sh_d;
    logic             tx_par_q, tx_par_d, tx_pen_q, tx_pen_d, tx_s2_q, tx_s2_d, tx_q, tx_d;
    logic             tx_tick, tx_end;

    assign tx_tick  = (tx_div_q == '0);
    assign tx_end   = tx_tick && (tx_ovs_q == '0);
    assign tx_ready = (tx_st_q == S_IDLE);
    assign tx       = tx_q;

    always_comb begin
        tx_st_d  = tx_st_q;
        tx_div_d = tx_div_q;
        tx_ovs_d = tx_ovs_q;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        tx_par_d = tx_par_q;
        tx_pen_d = tx_pen_q;
        tx_s2_d  = tx_s2_q;
        tx_d     = 1'b1;
        if (tx_st_q != S_IDLE) begin
            tx_div_d = tx_tick ? baud_div : tx_div_q - 1'b1;
            if (tx_tick) tx_ovs_d = (tx_ovs_q == '0) ? OVS_LAST : tx_ovs_q - 1'b1;
        end
        case (tx_st_q)
            S_IDLE: if (tx_valid) begin
                tx_st_d  = S_START;
                tx_div_d = baud_div;
                tx_ovs_d = OVS_LAST;
                tx_bit_d = len_m1;
                tx_sh_d  = tx_data;
                tx_par_d = (^(tx_data & len_mask)) ^ parity_type;
                tx_pen_d = parity_en;
                tx_s2_d  = stop2;
            end
            S_START:  if (tx_end) tx_st_d = S_DATA;
            S_DATA: if (tx_end) begin
                tx_sh_d = tx_sh_q >> 1;
                if (tx_bit_q == '0) tx_st_d = tx_pen_q ? S_PARITY : S_STOP1;
                else                tx_bit_d = tx_bit_q - 1'b1;
            end
            S_PARITY: if (tx_end) tx_st_d = S_STOP1;
            S_STOP1:  if (tx_end) tx_st_d = tx_s2_q ? S_STOP2 : S_IDLE;
            S_STOP2:  if (tx_end) tx_st_d = S_IDLE;
            default:  tx_st_d = S_IDLE;
        endcase
        case (tx_st_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = tx_sh_d[0];
            S_PARITY: tx_d = tx_par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_st_q  <= S_IDLE;
            tx_div_q <= '0;
            tx_ovs_q <= '0;
            tx_bit_q <= '0;
            tx_sh_q  <= '0;
            tx_par_q <= 1'b0;
            tx_pen_q <= 1'b0;
            tx_s2_q  <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            tx_st_q  <= tx_st_d;
            tx_div_q <= tx_div_d;
            tx_ovs_q <= tx_ovs_d;
            tx_bit_q <= tx_bit_d;
            tx_sh_q  <= tx_sh_d;
            tx_par_q <= tx_par_d;
            tx_pen_q <= tx_pen_d;
            tx_s2_q  <= tx_s2_d;
            tx_q     <= tx_d;
        end
    end

    state_t           rx_st_q, rx_st_d;
    logic [DIV_W-1:0] rx_div_q, rx_div_d;
    logic [OW-1:0]    rx_ovs_q, rx_ovs_d;
    logic [2:0]       rx_bit_q, rx_bit_d, rx_len_q, rx_len_d;
    logic [7:0]       rx_sh_q, rx_sh_d, rx_byte;
    logic             rx_pen_q, rx_pen_d, rx_pt_q, rx_pt_d, rx_s2_q, rx_s2_d, rx_pacc_q, rx_pacc_d;
    logic             rx_m_q, rx_s_q, rx_prev_q;
    logic             rx_tick, rx_samp, rx_end, rx_push, perr_set, ferr_set, ovr_set;
    logic             perr_q, ferr_q, ovr_q;

    assign rx_tick = (rx_div_q == '0);
    assign rx_samp = rx_tick && (rx_ovs_q == OVS_MID);
    assign rx_end  = rx_tick && (rx_ovs_q == '0);
    // bits were shifted in from the MSB, so right-align to zero-extend short frames
    assign rx_byte = rx_sh_q >> (3'd7 - rx_len_q);

    always_comb begin
        rx_st_d   = rx_st_q;
        rx_div_d  = rx_div_q;
        rx_ovs_d  = rx_ovs_q;
        rx_bit_d  = rx_bit_q;
        rx_len_d  = rx_len_q;
        rx_sh_d   = rx_sh_q;
        rx_pen_d  = rx_pen_q;
        rx_pt_d   = rx_pt_q;
        rx_s2_d   = rx_s2_q;
        rx_pacc_d = rx_pacc_q;
        rx_push   = 1'b0;
        perr_set  = 1'b0;
        ferr_set  = 1'b0;
        if (rx_st_q != S_IDLE) begin
            rx_div_d = rx_tick ? baud_div : rx_div_q - 1'b1;
            if (rx_tick) rx_ovs_d = (rx_ovs_q == '0) ? OVS_LAST : rx_ovs_q - 1'b1;
        end
        case (rx_st_q)
            S_IDLE: if (rx_prev_q && !rx_s_q) begin
                rx_st_d   = S_START;
                rx_div_d  = baud_div;
                rx_ovs_d  = OVS_LAST;
                rx_bit_d  = len_m1;
                rx_len_d  = len_m1;
                rx_pen_d  = parity_en;
                rx_pt_d   = parity_type;
                rx_s2_d   = stop2;
                rx_pacc_d = 1'b0;
            end
            S_START: begin
                if (rx_samp && rx_s_q) rx_st_d = S_IDLE;
                else if (rx_end)       rx_st_d = S_DATA;
            end
            S_DATA: begin
                if (rx_samp) begin
                    rx_sh_d   = {rx_s_q, rx_sh_q[7:1]};
                    rx_pacc_d = rx_pacc_q ^ rx_s_q;
                end
                if (rx_end) begin
                    if (rx_bit_q == '0) rx_st_d = rx_pen_q ? S_PARITY : S_STOP1;
                    else                rx_bit_d = rx_bit_q - 1'b1;
                end
            end
            S_PARITY: begin
                if (rx_samp) perr_set = rx_s_q ^ rx_pacc_q ^ rx_pt_q;
                if (rx_end)  rx_st_d = S_STOP1;
            end
            S_STOP1: begin
                if (rx_samp) begin
                    ferr_set = !rx_s_q;
                    if (!rx_s2_q) begin
                        rx_push = 1'b1;
                        rx_st_d = S_IDLE;
                    end
                end else if (rx_end) begin
                    rx_st_d = S_STOP2;
                end
            end
            S_STOP2: if (rx_samp) begin
                ferr_set = !rx_s_q;
                rx_push  = 1'b1;
                rx_st_d  = S_IDLE;
            end
            default: rx_st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m_q    <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            rx_st_q   <= S_IDLE;
            rx_div_q  <= '0;
            rx_ovs_q  <= '0;
            rx_bit_q  <= '0;
            rx_len_q  <= '0;
            rx_sh_q   <= '0;
            rx_pen_q  <= 1'b0;
            rx_pt_q   <= 1'b0;
            rx_s2_q   <= 1'b0;
            rx_pacc_q <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_m_q    <= rx;
            rx_s_q    <= rx_m_q;
            rx_prev_q <= rx_s_q;
            rx_st_q   <= rx_st_d;
            rx_div_q  <= rx_div_d;
            rx_ovs_q  <= rx_ovs_d;
            rx_bit_q  <= rx_bit_d;
            rx_len_q  <= rx_len_d;
            rx_sh_q   <= rx_sh_d;
            rx_pen_q  <= rx_pen_d;
            rx_pt_q   <= rx_pt_d;
            rx_s2_q   <= rx_s2_d;
            rx_pacc_q <= rx_pacc_d;
            perr_q    <= perr_q | perr_set;
            ferr_q    <= ferr_q | ferr_set;
            ovr_q     <= ovr_q | ovr_set;
        end
    end

    assign rx_parity_err = perr_q;
    assign rx_frame_err  = ferr_q;
    assign rx_overrun    = ovr_q;

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          pop, full, push_ok;

    assign pop      = rx_valid && rx_ready;
    assign full     = (cnt_q == (AW+1)'(FIFO_DEPTH));
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push_ok  = rx_push && (!full || pop);
    assign ovr_set  = rx_push && full && !pop;
    assign rx_valid = (cnt_q != '0);
    assign rx_data  = mem_q[rd_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= rx_byte;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
`else
    localparam int unused_fifo_depth = FIFO_DEPTH;
    logic [7:0] hold_q;
    logic       hold_v_q, pop;

    assign pop      = hold_v_q && rx_ready;
    assign ovr_set  = rx_push && hold_v_q && !pop;
    assign rx_valid = hold_v_q;
    assign rx_data  = hold_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q   <= '0;
            hold_v_q <= 1'b0;
        end else if (rx_push) begin
            hold_q   <= rx_byte;
            hold_v_q <= 1'b1;
        end else if (pop) begin
            hold_v_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_param.sv
// Self-checking bench for uart_param: frame-level TX waveform model plus an RX byte scoreboard.
module tb_uart_param;
    localparam int OVS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] baud_div = '0;
    logic [3:0]  length = 4'd8;
    logic        parity_en = 1'b0, parity_type = 1'b0, stop2 = 1'b0;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = '0;
    logic        tx_ready, tx, rx;
    logic        rx_valid, rx_ready = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_parity_err, rx_frame_err, rx_overrun;
    logic        loop = 1'b0, rx_drv = 1'b1;

    assign rx = loop ? tx : rx_drv;

    uart_param dut (
        .clk(clk), .rst(rst), .baud_div(baud_div), .length(length),
        .parity_en(parity_en), .parity_type(parity_type), .stop2(stop2),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .tx(tx),
        .rx(rx), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic       fb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor: every completed RX handshake consumes one expected byte
    always @(negedge clk) begin : mon
        logic [7:0] e;
        if (!rst && rx_valid && rx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected: got byte %02h, required none", rx_data);
            end else begin
                e = exp_q.pop_front();
                if (rx_data !== e) begin
                    errors++;
                    $display("FAIL rx_data: got %02h, required %02h", rx_data, e);
                end
            end
        end
    end

    function automatic int norm_len(input int l);
        return (l < 5 || l > 8) ? 8 : l;
    endfunction

    // reference frame: start, n data bits LSB first, optional parity, 1 or 2 stop bits
    task automatic build_frame(input logic [7:0] d, input int n, input bit pen, input bit pt, input bit s2);
        int ones = 0;
        fb.delete();
        fb.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            fb.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pen) fb.push_back(((ones % 2) == 1) ^ pt);
        fb.push_back(1'b1);
        if (s2) fb.push_back(1'b1);
    endtask

    function automatic logic [7:0] exp_byte(input logic [7:0] d, input int n);
        return d & 8'((1 << n) - 1);
    endfunction

    task automatic set_cfg(input int bd, input int len_raw, input bit pen, input bit pt, input bit s2);
        baud_div    = 16'(bd);
        length      = 4'(len_raw);
        parity_en   = pen;
        parity_type = pt;
        stop2       = s2;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic accept(input logic [7:0] d);
        int k = 0;
        while (!tx_ready && k < 20000) begin
            @(posedge clk); #1;
            k++;
        end
        chk("tx_ready_before_send", 32'(tx_ready), 32'd1);
        tx_valid = 1'b1;
        tx_data  = d;
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    // send one frame, checking each bit centre and the exact frame length
    task automatic send_frame(input logic [7:0] d, input int bd, input int len_raw, input bit pen,
                              input bit pt, input bit s2, input bit push, input bit scramble);
        int n, p, dur, k;
        bit done;
        set_cfg(bd, len_raw, pen, pt, s2);
        n = norm_len(len_raw);
        build_frame(d, n, pen, pt, s2);
        if (push) exp_q.push_back(exp_byte(d, n));
        p   = OVS * (bd + 1);
        dur = fb.size() * p;
        accept(d);
        k    = 0;
        done = 1'b0;
        while (!done && k < dur + 100) begin
            @(posedge clk); #1;
            k++;
            if ((k % p) == p / 2 && (k / p) < fb.size()) chk("tx_bit", 32'(tx), 32'(fb[k / p]));
            if (k == 20 && scramble) begin
                tx_data     = 8'($urandom);
                length      = 4'($urandom_range(0, 15));
                parity_en   = 1'($urandom);
                parity_type = 1'($urandom);
                stop2       = 1'($urandom);
            end
            if (tx_ready) done = 1'b1;
        end
        chk("frame_len", 32'(k), 32'(dur));
    endtask

    task automatic bang_rx(input logic [7:0] d, input int bd, input bit bad_stop);
        int p = OVS * (bd + 1);
        set_cfg(bd, 8, 1'b0, 1'b0, 1'b0);
        build_frame(d, 8, 1'b0, 1'b0, 1'b0);
        if (bad_stop) fb[fb.size() - 1] = 1'b0;
        for (int i = 0; i < fb.size(); i++) begin
            rx_drv = fb[i];
            repeat (p) @(posedge clk);
            #1;
        end
        rx_drv = 1'b1;
        repeat (p) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 5000) begin
            @(posedge clk); #1;
            k++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_flags(input logic p, input logic f, input logic o);
        chk("rx_parity_err", 32'(rx_parity_err), 32'(p));
        chk("rx_frame_err", 32'(rx_frame_err), 32'(f));
        chk("rx_overrun", 32'(rx_overrun), 32'(o));
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_tx_ready", 32'(tx_ready), 32'd1);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        chk_flags(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("tx_ready_after_release", 32'(tx_ready), 32'd1);

        // 0xA5, 8N1, divisor 0: 160-cycle frame
        loop = 1'b0;
        send_frame(8'hA5, 0, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // loopback 7 data bits, odd parity, two stop bits, divisor 3: 704-cycle frame
        loop = 1'b1;
        send_frame(8'h55, 3, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_drain();
        chk_flags(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++)
            send_frame(8'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 15)),
                       1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b1);
        wait_drain();
        chk_flags(1'b0, 1'b0, 1'b0);

        // short low glitch on idle line must be rejected
        loop = 1'b0;
        set_cfg(0, 8, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1 rx_drv = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx_drv = 1'b1;
        repeat (400) @(posedge clk);
        #1;
        chk("glitch_rx_valid", 32'(rx_valid), 32'd0);
        chk_flags(1'b0, 1'b0, 1'b0);
        exp_q.push_back(8'h96);
        bang_rx(8'h96, 0, 1'b0);
        wait_drain();

        exp_q.push_back(8'h3C);
        bang_rx(8'h3C, 1, 1'b1);
        wait_drain();
        chk_flags(1'b0, 1'b1, 1'b0);

        // overrun with consumer stalled
        do_reset();
        loop     = 1'b1;
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++)
            send_frame(8'(i), 0, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("overrun_valid", 32'(rx_valid), 32'd1);
        chk("rx_overrun", 32'(rx_overrun), 32'd1);
`ifdef UART_RX_FIFO_EN
        chk("overrun_head", 32'(rx_data), 32'h01);
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
`else
        chk("overrun_head", 32'(rx_data), 32'h05);
        exp_q.push_back(8'h05);
`endif
        rx_ready = 1'b1;
        wait_drain();
        repeat (2) @(posedge clk);
        #1;
        chk("overrun_empty", 32'(rx_valid), 32'd0);

        // reset in the middle of a looped-back frame
        do_reset();
        loop = 1'b1;
        set_cfg(0, 8, 1'b0, 1'b0, 1'b0);
        accept(8'h00);
        repeat (40) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset_tx", 32'(tx), 32'd1);
        chk("midreset_tx_ready", 32'(tx_ready), 32'd1);
        chk("midreset_rx_valid", 32'(rx_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("midreset_ready_after", 32'(tx_ready), 32'd1);
        repeat (400) @(posedge clk);
        #1;
        chk("midreset_no_byte", 32'(rx_valid), 32'd0);
        chk("midreset_tx_idle", 32'(tx), 32'd1);
        chk_flags(1'b0, 1'b0, 1'b0);
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
